// File: rtl/led_pkg.sv
// Shared types and widths for the LED brightness path (fade engine and PWM stage).
package led_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } fade_state_t;

  // Duty width shared by the fade engine and the PWM generator.
  localparam int DUTY_W = 8;

endpackage

// File: rtl/fade_tick_gen.sv
// Step-interval timer: counts enabled cycles and fires a one-cycle tick every
// 'interval' enabled cycles. The count freezes while disabled, so no tick is
// lost or added across a pause.
module fade_tick_gen #(
  parameter int INTERVAL_W = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic [INTERVAL_W-1:0] interval,
  output logic                  tick
);

  localparam logic [INTERVAL_W-1:0] ONE = {{(INTERVAL_W-1){1'b0}}, 1'b1};

  logic [INTERVAL_W-1:0] cnt_q, cnt_d;
  logic                  at_end;

  // Terminal count is interval-1; interval is never 0 here (substituted upstream).
  assign at_end = (cnt_q == (interval - ONE));
  assign tick   = en && at_end;

  // Next count: clear wins, wrap to 0 on tick, otherwise advance only when enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + ONE;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_fade_ctrl.sv
// Brightness fade engine: accepts a target duty over valid/ready and ramps the
// registered duty output toward it in saturating steps, one step per interval.
//
//   state | meaning
//   IDLE  | no fade in progress; ready for a request when not sleeping
//   UP    | stepping duty upward toward the latched level
//   DOWN  | stepping duty downward toward the latched level
module led_fade_ctrl
  import led_pkg::*;
#(
  parameter int WIDTH      = DUTY_W,
  parameter int INTERVAL_W = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sleep,
  input  logic                  tgt_valid,
  output logic                  tgt_ready,
  input  logic [WIDTH-1:0]      tgt_level,
  input  logic [WIDTH-1:0]      tgt_step,
  input  logic [INTERVAL_W-1:0] tgt_interval,
  output logic [WIDTH-1:0]      duty,
  output logic                  busy,
  output logic                  done
);

  localparam logic [WIDTH-1:0]      STEP_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [INTERVAL_W-1:0] INTV_ONE = {{(INTERVAL_W-1){1'b0}}, 1'b1};

  fade_state_t           state_q, state_d;
  logic [WIDTH-1:0]      duty_q, duty_d;
  logic [WIDTH-1:0]      level_q, level_d;
  logic [WIDTH-1:0]      step_q, step_d;
  logic [INTERVAL_W-1:0] interval_q, interval_d;
  logic                  done_q, done_d;

  logic                  accept;
  logic                  tick;
  logic [WIDTH:0]        sum_w;
  logic [WIDTH:0]        diff_w;

  assign tgt_ready = (state_q == IDLE) && !sleep;
  assign accept    = tgt_valid && tgt_ready;
  assign busy      = (state_q != IDLE);
  assign duty      = duty_q;
  assign done      = done_q;

  // One extra bit exposes overflow on the way up and underflow on the way down.
  assign sum_w  = {1'b0, duty_q} + {1'b0, step_q};
  assign diff_w = {1'b0, duty_q} - {1'b0, step_q};

  fade_tick_gen #(
    .INTERVAL_W (INTERVAL_W)
  ) u_tick (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (busy && !sleep),
    .clr      (accept),
    .interval (interval_q),
    .tick     (tick)
  );

  // Next-state, request latching and saturating duty steps.
  always_comb begin
    state_d    = state_q;
    duty_d     = duty_q;
    level_d    = level_q;
    step_d     = step_q;
    interval_d = interval_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          level_d    = tgt_level;
          step_d     = (tgt_step == '0) ? STEP_ONE : tgt_step;
          interval_d = (tgt_interval == '0) ? INTV_ONE : tgt_interval;
          if (tgt_level > duty_q) begin
            state_d = UP;
          end else if (tgt_level < duty_q) begin
            state_d = DOWN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      UP: begin
        if (tick) begin
          if (sum_w >= {1'b0, level_q}) begin
            duty_d  = level_q;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            duty_d = sum_w[WIDTH-1:0];
          end
        end
      end
      DOWN: begin
        if (tick) begin
          if (diff_w[WIDTH] || (diff_w[WIDTH-1:0] <= level_q)) begin
            duty_d  = level_q;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            duty_d = diff_w[WIDTH-1:0];
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      duty_q     <= '0;
      level_q    <= '0;
      step_q     <= STEP_ONE;
      interval_q <= INTV_ONE;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      duty_q     <= duty_d;
      level_q    <= level_d;
      step_q     <= step_d;
      interval_q <= interval_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_led_fade_ctrl.sv
// Directed bench for led_fade_ctrl: outputs sampled and inputs driven on the
// falling clock edge; the design acts on the rising edge.
module tb_led_fade_ctrl;

  logic        clk;
  logic        reset_n;
  logic        sleep;
  logic        tgt_valid;
  logic        tgt_ready;
  logic [7:0]  tgt_level;
  logic [7:0]  tgt_step;
  logic [15:0] tgt_interval;
  logic [7:0]  duty;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  led_fade_ctrl #(
    .WIDTH      (8),
    .INTERVAL_W (16)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sleep        (sleep),
    .tgt_valid    (tgt_valid),
    .tgt_ready    (tgt_ready),
    .tgt_level    (tgt_level),
    .tgt_step     (tgt_step),
    .tgt_interval (tgt_interval),
    .duty         (duty),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic request(input logic [7:0] lvl, input logic [7:0] stp, input logic [15:0] itv);
    tgt_valid    = 1'b1;
    tgt_level    = lvl;
    tgt_step     = stp;
    tgt_interval = itv;
  endtask

  initial begin
    logic [7:0] down_seq [4];
    down_seq = '{8'h30, 8'h20, 8'h10, 8'h05};

    reset_n      = 1'b0;
    sleep        = 1'b0;
    tgt_valid    = 1'b0;
    tgt_level    = '0;
    tgt_step     = '0;
    tgt_interval = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_duty",  32'(duty), 32'h00);
    chk("rst_ready", 32'(tgt_ready), 32'h1);
    chk("rst_busy",  32'(busy), 32'h0);
    chk("rst_done",  32'(done), 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Fade up 0 -> 0x40, step 0x10, interval 4.
    request(8'h40, 8'h10, 16'd4);
    @(negedge clk);
    tgt_valid = 1'b0;
    chk("up_acc_busy",  32'(busy), 32'h1);
    chk("up_acc_ready", 32'(tgt_ready), 32'h0);
    chk("up_acc_duty",  32'(duty), 32'h00);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk($sformatf("up_duty_%0d", k), 32'(duty), 32'(16 * (k / 4)));
      chk($sformatf("up_busy_%0d", k), 32'(busy), 32'(k < 16));
      chk($sformatf("up_done_%0d", k), 32'(done), 32'(k == 16));
    end
    chk("up_end_ready", 32'(tgt_ready), 32'h1);
    @(negedge clk);
    chk("up_done_clr", 32'(done), 32'h0);

    // Fade down 0x40 -> 0x05, step 0x10, interval 1: clamps at level.
    request(8'h05, 8'h10, 16'd1);
    @(negedge clk);
    tgt_valid = 1'b0;
    chk("dn_acc_duty", 32'(duty), 32'h40);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("dn_duty_%0d", k), 32'(duty), 32'(down_seq[k]));
      chk($sformatf("dn_done_%0d", k), 32'(done), 32'(k == 3));
    end
    @(negedge clk);
    chk("dn_done_clr", 32'(done), 32'h0);

    // 0x05 -> 0xF0 with step 0xF0: one saturating step.
    request(8'hF0, 8'hF0, 16'd1);
    @(negedge clk);
    tgt_valid = 1'b0;
    @(negedge clk);
    chk("sat_f0_duty", 32'(duty), 32'hF0);
    chk("sat_f0_done", 32'(done), 32'h1);

    // 0xF0 -> 0xFF, step 0x20, interval 2: no wrap.
    request(8'hFF, 8'h20, 16'd2);
    @(negedge clk);
    tgt_valid = 1'b0;
    @(negedge clk);
    chk("wrap_mid_duty", 32'(duty), 32'hF0);
    @(negedge clk);
    chk("wrap_duty", 32'(duty), 32'hFF);
    chk("wrap_done", 32'(done), 32'h1);

    // Step 0 behaves as 1; interval 0 behaves as 1.
    request(8'hFD, 8'h00, 16'd0);
    @(negedge clk);
    tgt_valid = 1'b0;
    @(negedge clk);
    chk("step0_duty1", 32'(duty), 32'hFE);
    chk("step0_done1", 32'(done), 32'h0);
    @(negedge clk);
    chk("step0_duty2", 32'(duty), 32'hFD);
    chk("step0_done2", 32'(done), 32'h1);

    // 0xFD -> 0x00 with step 0xFF: no underflow.
    request(8'h00, 8'hFF, 16'd1);
    @(negedge clk);
    tgt_valid = 1'b0;
    @(negedge clk);
    chk("uflow_duty", 32'(duty), 32'h00);
    chk("uflow_done", 32'(done), 32'h1);
    @(negedge clk);

    // Level equal to duty: done on the accept edge, never busy.
    request(8'h00, 8'h01, 16'd3);
    @(negedge clk);
    tgt_valid = 1'b0;
    chk("eq_done",  32'(done), 32'h1);
    chk("eq_busy",  32'(busy), 32'h0);
    chk("eq_duty",  32'(duty), 32'h00);
    chk("eq_ready", 32'(tgt_ready), 32'h1);
    @(negedge clk);
    chk("eq_done_clr", 32'(done), 32'h0);

    // Fade with valid held high and inputs changing, then sleep after 2 counts.
    request(8'h40, 8'h10, 16'd4);
    @(negedge clk);
    tgt_level    = 8'h80;
    tgt_step     = 8'h01;
    tgt_interval = 16'd1;
    chk("hold_busy",  32'(busy), 32'h1);
    chk("hold_ready", 32'(tgt_ready), 32'h0);
    repeat (2) @(negedge clk);
    sleep = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("slp_duty_%0d", k), 32'(duty), 32'h00);
      chk($sformatf("slp_ready_%0d", k), 32'(tgt_ready), 32'h0);
    end
    sleep = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      chk($sformatf("wake_duty_%0d", k), 32'(duty), 32'(16 * ((k + 2) / 4)));
      chk($sformatf("wake_done_%0d", k), 32'(done), 32'(k == 14));
    end
    tgt_valid = 1'b0;
    @(negedge clk);
    chk("wake_final_busy", 32'(busy), 32'h0);
    chk("wake_final_duty", 32'(duty), 32'h40);

    // Asynchronous reset in the middle of a fade.
    request(8'h00, 8'h01, 16'd1);
    @(negedge clk);
    tgt_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_arst_duty", 32'(duty), 32'h3D);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_duty",  32'(duty), 32'h00);
    chk("arst_busy",  32'(busy), 32'h0);
    chk("arst_ready", 32'(tgt_ready), 32'h1);
    chk("arst_done",  32'(done), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_arst_duty", 32'(duty), 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
